// File: rtl/branch_resolve.sv
// Branch resolution unit with a one-deep registered result stage.
//
// It decodes the RISC-V conditional branch opcode and compares rs1 and rs2.
// From that it produces taken, illegal and mispredict, plus the branch target
// pc + B-immediate. It also counts accepted branches and mispredicts in
// saturating counters.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid_i / in_ready_o    input handshake (in_ready_o is combinational)
//   inst_i                     instruction word
//   rs1_data_i, rs2_data_i     compare operands
//   pc_i                       address of inst_i
//   pred_taken_i               front-end prediction for inst_i
//   flush_i                    kills the held result and blocks capture
//   clr_cnt_i                  clears both statistics counters
//   out_valid_o / out_ready_i  output handshake
//   br_un_o .. illegal_o       registered compare/resolve flags
//   target_o                   registered branch target
//   br_cnt_o, mispred_cnt_o    saturating statistics counters
module branch_resolve #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      inst_i,
  input  logic [XLEN-1:0]  rs1_data_i,
  input  logic [XLEN-1:0]  rs2_data_i,
  input  logic [XLEN-1:0]  pc_i,
  input  logic             pred_taken_i,
  input  logic             flush_i,
  input  logic             clr_cnt_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             br_un_o,
  output logic             br_eq_o,
  output logic             br_lt_o,
  output logic             taken_o,
  output logic             mispredict_o,
  output logic             illegal_o,
  output logic [XLEN-1:0]  target_o,
  output logic [CNT_W-1:0] br_cnt_o,
  output logic [CNT_W-1:0] mispred_cnt_o
);

  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            is_branch;
  logic            accept;
  logic [XLEN-1:0] imm_b;

  logic            br_un_d, br_eq_d, br_lt_d, taken_d, illegal_d, mispredict_d;
  logic [XLEN-1:0] target_d;
  logic            br_un_q, br_eq_q, br_lt_q, taken_q, illegal_q, mispredict_q;
  logic [XLEN-1:0] target_q;
  logic            out_valid_d, out_valid_q;
  logic [CNT_W-1:0] br_cnt_d, br_cnt_q, mispred_cnt_d, mispred_cnt_q;

  // Register-select fields are not needed here.
  logic unused_inst;
  assign unused_inst = ^inst_i[24:15];

  assign opcode    = inst_i[6:0];
  assign funct3    = inst_i[14:12];
  assign is_branch = (opcode == OpBranch);

  assign in_ready_o = !out_valid_q || out_ready_i;
  assign accept     = in_valid_i && in_ready_o && !flush_i;

  assign imm_b = {{(XLEN-13){inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                  inst_i[11:8], 1'b0};

  // Decode and compare.
  always_comb begin
    br_un_d   = is_branch && (funct3[2:1] == 2'b11);
    br_eq_d   = (rs1_data_i == rs2_data_i);
    br_lt_d   = br_un_d ? (rs1_data_i < rs2_data_i)
                        : ($signed(rs1_data_i) < $signed(rs2_data_i));
    taken_d   = 1'b0;
    illegal_d = 1'b0;
    if (is_branch) begin
      unique case (funct3)
        3'b000:         taken_d = br_eq_d;
        3'b001:         taken_d = !br_eq_d;
        3'b100, 3'b110: taken_d = br_lt_d;
        3'b101, 3'b111: taken_d = !br_lt_d;
        default:        illegal_d = 1'b1;
      endcase
    end
    mispredict_d = taken_d ^ pred_taken_i;
    target_d     = pc_i + imm_b;
  end

  // Handshake and counter next state.
  always_comb begin
    if (flush_i) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    br_cnt_d      = br_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (clr_cnt_i) begin
      br_cnt_d      = '0;
      mispred_cnt_d = '0;
    end else if (accept) begin
      if (is_branch && (br_cnt_q != CntMax)) begin
        br_cnt_d = br_cnt_q + CntOne;
      end
      if (mispredict_d && (mispred_cnt_q != CntMax)) begin
        mispred_cnt_d = mispred_cnt_q + CntOne;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q   <= 1'b0;
      br_un_q       <= 1'b0;
      br_eq_q       <= 1'b0;
      br_lt_q       <= 1'b0;
      taken_q       <= 1'b0;
      illegal_q     <= 1'b0;
      mispredict_q  <= 1'b0;
      target_q      <= '0;
      br_cnt_q      <= '0;
      mispred_cnt_q <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      br_cnt_q      <= br_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
      if (accept) begin
        br_un_q      <= br_un_d;
        br_eq_q      <= br_eq_d;
        br_lt_q      <= br_lt_d;
        taken_q      <= taken_d;
        illegal_q    <= illegal_d;
        mispredict_q <= mispredict_d;
        target_q     <= target_d;
      end
    end
  end

  assign out_valid_o   = out_valid_q;
  assign br_un_o       = br_un_q;
  assign br_eq_o       = br_eq_q;
  assign br_lt_o       = br_lt_q;
  assign taken_o       = taken_q;
  assign illegal_o     = illegal_q;
  assign mispredict_o  = mispredict_q;
  assign target_o      = target_q;
  assign br_cnt_o      = br_cnt_q;
  assign mispred_cnt_o = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolve.sv
module tb_branch_resolve;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] inst = '0, rs1 = '0, rs2 = '0, pc = '0;
  logic        pred = 1'b0, flush = 1'b0, clr = 1'b0;

  logic        in_ready, out_valid, br_un, br_eq, br_lt, taken, mis, ill;
  logic [31:0] target;
  logic [15:0] br_cnt, mis_cnt;

  logic        s_in_ready, s_out_valid, s_br_un, s_br_eq, s_br_lt, s_taken, s_mis, s_ill;
  logic [31:0] s_target;
  logic [1:0]  s_br_cnt, s_mis_cnt;

  always #5 clk = ~clk;

  branch_resolve #(.XLEN(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .inst_i(inst), .rs1_data_i(rs1), .rs2_data_i(rs2), .pc_i(pc),
    .pred_taken_i(pred), .flush_i(flush), .clr_cnt_i(clr),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .br_un_o(br_un), .br_eq_o(br_eq), .br_lt_o(br_lt), .taken_o(taken),
    .mispredict_o(mis), .illegal_o(ill), .target_o(target),
    .br_cnt_o(br_cnt), .mispred_cnt_o(mis_cnt)
  );

  // Narrow-counter instance sharing the same stimulus, for saturation.
  branch_resolve #(.XLEN(32), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(s_in_ready),
    .inst_i(inst), .rs1_data_i(rs1), .rs2_data_i(rs2), .pc_i(pc),
    .pred_taken_i(pred), .flush_i(flush), .clr_cnt_i(clr),
    .out_valid_o(s_out_valid), .out_ready_i(out_ready),
    .br_un_o(s_br_un), .br_eq_o(s_br_eq), .br_lt_o(s_br_lt), .taken_o(s_taken),
    .mispredict_o(s_mis), .illegal_o(s_ill), .target_o(s_target),
    .br_cnt_o(s_br_cnt), .mispred_cnt_o(s_mis_cnt)
  );

  typedef struct {
    logic [31:0] inst, rs1, rs2, pc;
    logic        pred;
    logic        un, eq, lt, tk, mis, ill;
    logic [31:0] tgt;
  } vec_t;

  vec_t vecs[9];
  int   checks = 0;
  int   failures = 0;
  int   exp_br = 0;
  int   exp_mis = 0;

  function automatic logic [31:0] enc_br(input logic [2:0] f3, input logic [12:0] imm);
    enc_br = {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic vec_t mk(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] p, input logic pr, input logic un,
                              input logic eq, input logic lt, input logic tk, input logic ms,
                              input logic il, input logic [31:0] tg);
    vec_t v;
    v.inst = i; v.rs1 = a; v.rs2 = b; v.pc = p; v.pred = pr;
    v.un = un; v.eq = eq; v.lt = lt; v.tk = tk; v.mis = ms; v.ill = il; v.tgt = tg;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    inst = v.inst; rs1 = v.rs1; rs2 = v.rs2; pc = v.pc; pred = v.pred;
  endtask

  task automatic chk_result(input string tag, input vec_t v);
    chk({tag, ".out_valid"}, 64'(out_valid), 64'd1);
    chk({tag, ".br_un"}, 64'(br_un), 64'(v.un));
    chk({tag, ".br_eq"}, 64'(br_eq), 64'(v.eq));
    chk({tag, ".br_lt"}, 64'(br_lt), 64'(v.lt));
    chk({tag, ".taken"}, 64'(taken), 64'(v.tk));
    chk({tag, ".mispredict"}, 64'(mis), 64'(v.mis));
    chk({tag, ".illegal"}, 64'(ill), 64'(v.ill));
    chk({tag, ".target"}, 64'(target), 64'(v.tgt));
  endtask

  task automatic model_accept(input vec_t v);
    if (v.inst[6:0] == 7'b1100011) exp_br++;
    if (v.mis) exp_mis++;
  endtask

  initial begin
    //          inst                         rs1           rs2           pc            pr un eq lt tk ms il target
    vecs[0] = mk(enc_br(3'b110, 13'h0010),   32'h1,        32'hFFFF_FFFF, 32'h200,     0, 1, 0, 1, 1, 1, 0, 32'h210);
    vecs[1] = mk(enc_br(3'b100, 13'h0010),   32'h1,        32'hFFFF_FFFF, 32'h200,     0, 0, 0, 0, 0, 0, 0, 32'h210);
    vecs[2] = mk(enc_br(3'b000, 13'h1FF8),   32'h5,        32'h5,         32'h100,     1, 0, 1, 0, 1, 0, 0, 32'h0F8);
    vecs[3] = mk(enc_br(3'b001, 13'h0004),   32'h5,        32'h5,         32'h100,     1, 0, 1, 0, 0, 1, 0, 32'h104);
    vecs[4] = mk(enc_br(3'b101, 13'h1000),   32'hFFFF_FFFE, 32'h3,        32'h1000,    0, 0, 0, 1, 0, 0, 0, 32'h0);
    vecs[5] = mk(enc_br(3'b111, 13'h0020),   32'hFFFF_FFFE, 32'h3,        32'hFFFF_FFF0, 0, 1, 0, 0, 1, 1, 0, 32'h10);
    vecs[6] = mk(enc_br(3'b010, 13'h0FFE),   32'h1,        32'h2,         32'h0,       1, 0, 0, 1, 0, 1, 1, 32'hFFE);
    vecs[7] = mk(32'h8000_6033,              32'h1,        32'hFFFF_FFFF, 32'h2000,    1, 0, 0, 0, 0, 1, 0, 32'h1000);
    vecs[8] = mk(enc_br(3'b110, 13'h0000),   32'h7,        32'h7,         32'h40,      1, 1, 1, 0, 0, 1, 0, 32'h40);

    // Reset state, sampled while reset is held.
    #2;
    chk("rst.in_ready", 64'(in_ready), 64'd1);
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.target", 64'(target), 64'd0);
    chk("rst.br_cnt", 64'(br_cnt), 64'd0);
    chk("rst.mis_cnt", 64'(mis_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_rst.in_ready", 64'(in_ready), 64'd1);
    chk("post_rst.out_valid", 64'(out_valid), 64'd0);

    // Table: back-to-back accepts with out_ready held high.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i]);
      step();
      model_accept(vecs[i]);
      chk_result($sformatf("vec%0d", i), vecs[i]);
      chk($sformatf("vec%0d.br_cnt", i), 64'(br_cnt), 64'(exp_br));
      chk($sformatf("vec%0d.mis_cnt", i), 64'(mis_cnt), 64'(exp_mis));
    end
    // 8 branches and 6 mispredicts: 2-bit counters sit at 3.
    chk("sat.br_cnt", 64'(s_br_cnt), 64'd3);
    chk("sat.mis_cnt", 64'(s_mis_cnt), 64'd3);

    // Backpressure: capture BEQ, then hold for three cycles.
    drive(vecs[2]);
    step();
    model_accept(vecs[2]);
    chk_result("bp.load", vecs[2]);
    out_ready = 1'b0;
    drive(vecs[0]);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("bp%0d.in_ready", c), 64'(in_ready), 64'd0);
      step();
      chk_result($sformatf("bp%0d.hold", c), vecs[2]);
      chk($sformatf("bp%0d.br_cnt", c), 64'(br_cnt), 64'(exp_br));
    end
    out_ready = 1'b1;
    #1;
    chk("bp.release.in_ready", 64'(in_ready), 64'd1);
    step();
    model_accept(vecs[0]);
    chk_result("bp.next0", vecs[0]);
    drive(vecs[1]);
    step();
    model_accept(vecs[1]);
    chk_result("bp.next1", vecs[1]);
    chk("bp.br_cnt", 64'(br_cnt), 64'(exp_br));

    // Flush with in_valid high: nothing captured, counters untouched.
    flush = 1'b1;
    drive(vecs[0]);
    step();
    flush = 1'b0;
    chk("flush.out_valid", 64'(out_valid), 64'd0);
    chk("flush.br_cnt", 64'(br_cnt), 64'(exp_br));
    chk("flush.mis_cnt", 64'(mis_cnt), 64'(exp_mis));

    // Clear coinciding with an accepted mispredicted branch.
    clr = 1'b1;
    step();
    clr = 1'b0;
    exp_br = 0;
    exp_mis = 0;
    chk_result("clr", vecs[0]);
    chk("clr.br_cnt", 64'(br_cnt), 64'd0);
    chk("clr.mis_cnt", 64'(mis_cnt), 64'd0);
    chk("clr.sat_br_cnt", 64'(s_br_cnt), 64'd0);

    // Drain: out_ready without a new input empties the stage.
    in_valid = 1'b0;
    step();
    chk("drain.out_valid", 64'(out_valid), 64'd0);

    // Asynchronous reset while a result is stalled.
    in_valid = 1'b1;
    out_ready = 1'b0;
    drive(vecs[0]);
    step();
    in_valid = 1'b0;
    chk("ar.pre.out_valid", 64'(out_valid), 64'd1);
    chk("ar.pre.br_cnt", 64'(br_cnt), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar.out_valid", 64'(out_valid), 64'd0);
    chk("ar.taken", 64'(taken), 64'd0);
    chk("ar.target", 64'(target), 64'd0);
    chk("ar.br_cnt", 64'(br_cnt), 64'd0);
    chk("ar.mis_cnt", 64'(mis_cnt), 64'd0);
    chk("ar.in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("ar.post.out_valid", 64'(out_valid), 64'd0);
    chk("ar.post.in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    in_valid = 1'b1;
    drive(vecs[1]);
    step();
    in_valid = 1'b0;
    chk_result("ar.first", vecs[1]);
    chk("ar.first.br_cnt", 64'(br_cnt), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 SHALL have parameter XLEN, default 32: operand, PC and target width.
REQ-002 SHALL have parameter CNT_W, default 16: width of each statistics counter.
REQ-003 SHALL have one clock; reset is asynchronous and active-low: ports clk and rst_n.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  input bundle valid.
REQ-007 in_ready  output  1  unit can accept input this cycle.
REQ-008 inst  input  32  instruction word; opcode inst[6:0], funct3 inst[14:12].
REQ-009 rs1_data, rs2_data  input  XLEN each  compare operands.
REQ-010 pc  input  XLEN  address of inst.
REQ-011 pred_taken  input  1  front-end prediction for inst.
REQ-012 flush  input  1  synchronous pipeline kill.
REQ-013 clr_cnt  input  1  synchronous clear of both counters.
REQ-014 out_valid  output  1  result register holds a valid result.
REQ-015 out_ready  input  1  consumer accepts the result.
REQ-016 br_un, br_eq, br_lt, taken, mispredict, illegal  output  1 each  registered results.
REQ-017 target  output  XLEN  registered branch target.
REQ-018 br_cnt, mispred_cnt  output  CNT_W each  statistics counters.

Function
REQ-019 SHALL compute br_un=1 only for opcode 7'b1100011 with funct3 3'b110 (BLTU) or 3'b111 (BGEU); otherwise 0.
REQ-020 br_eq SHALL be (rs1_data==rs2_data); br_lt SHALL be signed rs1<rs2 when br_un=0, unsigned when br_un=1; both computed for every accepted inst.
REQ-021 For branch opcode, taken: 000 br_eq; 001 !br_eq; 100/110 br_lt; 101/111 !br_lt; 010/011 taken=0 and illegal=1.
REQ-022 Non-branch opcode: taken=0, illegal=0, br_un=0.
REQ-023 target SHALL be pc + sign-extended B-immediate {inst[31],inst[7],inst[30:25],inst[11:8],1'b0}, mod 2^XLEN (wrap-around, no overflow flag); computed for any opcode.
REQ-024 mispredict SHALL be taken XOR pred_taken, for every accepted inst including non-branch and illegal.
REQ-025 in_ready SHALL be combinational: !out_valid || out_ready.
REQ-026 Accept when in_valid && in_ready && !flush: all result outputs load on that clk edge; out_valid=1 next cycle; latency exactly 1 cycle.
REQ-027 out_valid && !out_ready SHALL hold every result output stable; no input accepted.
REQ-028 out_valid && out_ready with no accept SHALL clear out_valid next cycle; with accept, new result replaces old back-to-back (full throughput).
REQ-029 flush=1 SHALL clear out_valid next cycle and block capture that cycle, overriding in_valid and out_ready; result data registers may keep stale values.
REQ-030 br_cnt SHALL increment by 1 per accepted branch-opcode inst (including illegal funct3); mispred_cnt per accepted inst with mispredict=1.
REQ-031 Counters SHALL saturate at all-ones; no wrap.
REQ-032 clr_cnt SHALL set both counters to 0 next cycle, overriding a simultaneous increment.
REQ-033 Counters SHALL be unaffected by flush.

Reset
REQ-034 rst_n=0 SHALL immediately, independent of clk, force out_valid, all result outputs, target, br_cnt and mispred_cnt to 0.
REQ-035 Reset mid-transfer SHALL discard the held result; after release, first result appears 1 cycle after first accept.
REQ-036 in_ready SHALL read 1 during and right after reset.

Verification
REQ-037 BLTU inst, rs1=32'h0000_0001, rs2=32'hFFFF_FFFF, pred_taken=0 -> next cycle br_un=1, br_lt=1, taken=1, mispredict=1, br_cnt=1, mispred_cnt=1.
REQ-038 BLT same operands -> br_un=0, br_lt=0, taken=0; BEQ with rs1=rs2=5 and pc=32'h100, imm=-8 -> taken=1, target=32'h0F8.
REQ-039 Backpressure: out_ready=0 three cycles with in_valid=1 -> in_ready=0, outputs stable, one accept only; out_ready=1 -> back-to-back results each cycle.
REQ-040 flush coinciding with in_valid=1 -> out_valid=0 next cycle, br_cnt unchanged; clr_cnt with accepted branch -> br_cnt=0.
REQ-041 CNT_W=2, five accepted mispredicted branches -> br_cnt=mispred_cnt=3 (saturated); funct3=010 -> illegal=1, taken=0.
REQ-042 Assert rst_n=0 asynchronously while out_valid=1, out_ready=0 -> out_valid and counters 0 before next clk edge.
